// File: rtl/conv_window_3x3.sv
// 3x3 sliding-window generator: raster pixel stream in, one param9 window per valid (unpadded) position out.
// Optional CONV_WINDOW_CNT_EN adds the win_count port counting accepted windows per frame.
module conv_window_3x3 #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int NBITS = 20  // packConv::NBITS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NBITS-1:0]     in_pixel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [9*NBITS-1:0]   out_window,
`ifdef CONV_WINDOW_CNT_EN
  output logic [$clog2((IMG_W-2)*(IMG_H-2)+1)-1:0] win_count,
`endif
  output logic                 frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0]    col_reg;
  logic [RW-1:0]    row_reg;
  logic             last_reg;
  logic [NBITS-1:0] lb0 [IMG_W];
  logic [NBITS-1:0] lb1 [IMG_W];
  logic [NBITS-1:0] win_reg [9];
  logic [NBITS-1:0] new_col [3];
  logic             accept;
  logic             win_taken;

  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign win_taken = out_valid && out_ready;

  // Right column of the incoming window, top to bottom: row r-2, r-1, r.
  assign new_col[0] = lb1[col_reg];
  assign new_col[1] = lb0[col_reg];
  assign new_col[2] = in_pixel;

  // Line buffers are never cleared: rows 0-1 of each frame overwrite them before any window is emitted.
  always_ff @(posedge clock) begin
    if (accept) begin
      lb1[col_reg] <= lb0[col_reg];
      lb0[col_reg] <= in_pixel;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 9; i++) win_reg[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < 3; i++) begin
        win_reg[3*i]     <= win_reg[3*i+1];
        win_reg[3*i+1]   <= win_reg[3*i+2];
        win_reg[3*i+2]   <= new_col[i];
      end
    end
  end

  // The window registers are the output register; they only move on accepted pixels,
  // so a stalled window stays stable because in_ready is low.
  for (genvar gi = 0; gi < 9; gi++) begin : g_flat
    assign out_window[gi*NBITS +: NBITS] = win_reg[gi];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      col_reg    <= '0;
      row_reg    <= '0;
      out_valid  <= 1'b0;
      last_reg   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= win_taken && last_reg;
      if (accept) begin
        out_valid <= (row_reg >= ROW_TWO) && (col_reg >= COL_TWO);
        last_reg  <= (row_reg == ROW_LAST) && (col_reg == COL_LAST);
        if (col_reg == COL_LAST) begin
          col_reg <= '0;
          row_reg <= (row_reg == ROW_LAST) ? '0 : row_reg + 1'b1;
        end else begin
          col_reg <= col_reg + 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef CONV_WINDOW_CNT_EN
  localparam int NW = $clog2((IMG_W-2)*(IMG_H-2)+1);

  // Counter clears on the edge where frame_done is high; an acceptance on that edge starts the next frame at 1.
  always_ff @(posedge clock) begin
    if (reset) begin
      win_count <= '0;
    end else if (frame_done) begin
      win_count <= win_taken ? NW'(1) : '0;
    end else if (win_taken) begin
      win_count <= win_count + NW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_conv_window_3x3.sv
// Directed bench for conv_window_3x3 (4x4 frames) with a window scoreboard and per-cycle handshake model.
// When CONV_WINDOW_CNT_EN is defined, win_count is also checked every cycle.
module tb_conv_window_3x3;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int NB = 20;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b1;
  logic [NB-1:0]     in_pixel = '0;
  logic              in_ready;
  logic              out_valid;
  logic              frame_done;
  logic [9*NB-1:0]   out_window;
`ifdef CONV_WINDOW_CNT_EN
  localparam int NW = $clog2((W-2)*(H-2)+1);
  logic [NW-1:0]     win_count;
  int                wc_m = 0;
`endif

  always #5 clock = ~clock;

  conv_window_3x3 #(.IMG_W(W), .IMG_H(H), .NBITS(NB)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pixel   (in_pixel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_window (out_window),
`ifdef CONV_WINDOW_CNT_EN
    .win_count  (win_count),
`endif
    .frame_done (frame_done)
  );

  typedef struct {
    logic [9*NB-1:0] win;
    bit              last;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  logic [NB-1:0] img [H][W];
  int            r_m = 0;
  int            c_m = 0;
  bit            ov_m = 0;
  bit            fd_m = 0;

  function automatic logic [9*NB-1:0] build(int r, int c);
    logic [9*NB-1:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(3*i+j)*NB +: NB] = img[r-2+i][c-2+j];
    return w;
  endfunction

  // Window of a frame whose pixel values are tl + W*row + col, anchored at top-left value tl.
  function automatic logic [9*NB-1:0] win_lin(int tl);
    logic [9*NB-1:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(3*i+j)*NB +: NB] = NB'(tl + W*i + j);
    return w;
  endfunction

  task automatic chk(input string tag, input logic [9*NB-1:0] obs, input logic [9*NB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor: compare current outputs with the model, then advance the model to the next edge.
  always @(negedge clock) begin
    bit   hs, acc, fd_next;
    exp_t e;
    chk("out_valid", {179'b0, out_valid}, {179'b0, ov_m});
    chk("in_ready", {179'b0, in_ready}, {179'b0, (!ov_m || out_ready)});
    chk("frame_done", {179'b0, frame_done}, {179'b0, fd_m});
`ifdef CONV_WINDOW_CNT_EN
    chk("win_count", {{(9*NB-NW){1'b0}}, win_count}, (9*NB)'(wc_m));
`endif
    hs      = ov_m && out_ready;
    acc     = in_valid && (!ov_m || out_ready);
    fd_next = 0;
    if (reset) begin
      r_m = 0; c_m = 0; ov_m = 0; fd_m = 0;
      sb.delete();
`ifdef CONV_WINDOW_CNT_EN
      wc_m = 0;
`endif
    end else begin
      if (hs) begin
        checks++;
        assert (sb.size() > 0) else begin
          errors++;
          $error("FAIL window_unexpected: observed %h expected none", out_window);
        end
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("window", out_window, e.win);
          fd_next = e.last;
          $display("window accepted %h last=%0d", out_window, e.last);
        end
      end
`ifdef CONV_WINDOW_CNT_EN
      if (fd_m) wc_m = hs ? 1 : 0;
      else if (hs) wc_m++;
`endif
      if (acc) begin
        img[r_m][c_m] = in_pixel;
        ov_m = (r_m >= 2) && (c_m >= 2);
        if (ov_m) sb.push_back('{build(r_m, c_m), (r_m == H-1) && (c_m == W-1)});
        if (c_m == W-1) begin
          c_m = 0;
          r_m = (r_m == H-1) ? 0 : r_m + 1;
        end else begin
          c_m++;
        end
      end else if (hs) begin
        ov_m = 0;
      end
      fd_m = fd_next;
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic send(input int p);
    bit taken;
    int n;
    in_valid = 1'b1;
    in_pixel = NB'(p);
    n = 0;
    do begin
      @(negedge clock);
      taken = in_ready;
      tick();
      n++;
    end while (!taken && n < 50);
    checks++;
    assert (taken) else begin
      errors++;
      $error("FAIL send_timeout: observed in_ready=0 for %0d cycles expected acceptance of %0d", n, p);
    end
    in_valid = 1'b0;
  endtask

  task automatic stream(input int base, input int first, input int last, input bit bubble);
    for (int i = first; i <= last; i++) begin
      send(base + i);
      if (bubble) tick();
    end
  endtask

  task automatic drain;
    int n;
    n = 0;
    while ((sb.size() > 0 || fd_m) && n < 40) begin
      tick();
      n++;
    end
    tick();
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL drain_timeout: observed %0d pending expected 0", sb.size());
    end
  endtask

  initial begin
    tick();
    tick();
    chk("reset_out_valid", {179'b0, out_valid}, '0);
    chk("reset_in_ready", {179'b0, in_ready}, {179'b0, 1'b1});
    chk("reset_window", out_window, '0);
    chk("reset_frame_done", {179'b0, frame_done}, '0);
    reset = 1'b0;

    // Basic frame
    stream(0, 0, 10, 0);
    chk("basic_first_valid", {179'b0, out_valid}, {179'b0, 1'b1});
    chk("basic_first_window", out_window, win_lin(0));
    stream(0, 11, 15, 0);
    drain();

    // Backpressure on the first window
    stream(0, 0, 10, 0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pixel  = NB'(11);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("stall_in_ready", {179'b0, in_ready}, '0);
      chk("stall_window", out_window, win_lin(0));
      tick();
    end
    out_ready = 1'b1;
    stream(0, 11, 15, 0);
    drain();

    // Back-to-back frames
    stream(0, 0, 15, 0);
    stream(100, 0, 10, 0);
    chk("frame2_first_window", out_window, win_lin(100));
    stream(100, 11, 15, 0);
    drain();

    // Input bubbles
    stream(0, 0, 15, 1);
    drain();

    // Reset mid-frame
    stream(0, 0, 9, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset_out_valid", {179'b0, out_valid}, '0);
    stream(0, 0, 15, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
